// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx byte transmitter between N_REQ packet sources.
//   Arbitration is round-robin and the grant is locked for a whole packet,
//   so bytes from different sources never interleave on tx_serial. A stall
//   watchdog drops a grant whose owner stops supplying bytes mid-packet.
// Parameters
//   N_REQ    number of requesters (1..8)
//   TIMEOUT  SEND cycles the owner may hold req_valid low before abort
// Ports
//   comm_clk     in   system clock, posedge
//   reset        in   asynchronous active-high reset
//   req_valid    in   [N_REQ]   per-source byte available
//   req_data     in   [8*N_REQ] per-source byte, source i on [8i+7:8i]
//   req_last     in   [N_REQ]   byte is the final one of its packet
//   req_ready    out  [N_REQ]   byte accepted when valid & ready
//   grant        out  [N_REQ]   one-hot transmitter owner, 0 when idle
//   tx_flag      out            one-cycle load strobe to uart_tx
//   tx_byte      out  [8]       byte to uart_tx, held until next load
//   tx_busy      in             uart_tx busy
//   timeout_err  out            one-cycle pulse on watchdog abort
module uart_tx_arbiter #(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic               comm_clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               tx_flag,
   output logic [7:0]         tx_byte,
   input  logic               tx_busy,
   output logic               timeout_err
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t             r_state;
   logic [IW-1:0]      r_rr_ptr;
   logic [IW-1:0]      r_gidx;
   logic [N_REQ-1:0]   r_grant;
   logic [WW-1:0]      r_wdog;
   logic               r_last_q;
   logic               r_hold_cnt;
   logic               r_tx_flag;
   logic [7:0]         r_tx_byte;
   logic               r_timeout_err;

   logic [IW-1:0]      w_winner;
   logic [N_REQ-1:0]   w_winner_oh;
   logic               w_found;
   logic               w_can_accept;
   logic               w_handshake;
   logic               w_g_valid;
   logic               w_g_last;
   logic [7:0]         w_g_data;
   logic [IW-1:0]      w_next_ptr;

   // Index wrap for values below 2*N_REQ (no divider needed).
   function automatic logic [IW-1:0] f_wrap(input int unsigned a);
      return IW'((a >= N_REQ) ? (a - N_REQ) : a);
   endfunction

   // Round-robin scan: first valid source starting at r_rr_ptr, wrapping.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (!w_found && req_valid[f_wrap(32'(r_rr_ptr) + k)]) begin
            w_found  = 1'b1;
            w_winner = f_wrap(32'(r_rr_ptr) + k);
         end
      end
   end

   always_comb begin
      w_winner_oh           = '0;
      w_winner_oh[w_winner] = 1'b1;
   end

   assign w_g_valid    = req_valid[r_gidx];
   assign w_g_last     = req_last[r_gidx];
   assign w_g_data     = req_data[{r_gidx, 3'b000} +: 8];
   assign w_next_ptr   = f_wrap(32'(r_gidx) + 1);
   assign w_can_accept = (r_state == S_SEND) && !tx_busy && !r_tx_flag;
   assign w_handshake  = w_can_accept && w_g_valid;

   assign req_ready   = w_can_accept ? r_grant : '0;
   assign grant       = r_grant;
   assign tx_flag     = r_tx_flag;
   assign tx_byte     = r_tx_byte;
   assign timeout_err = r_timeout_err;

   always_ff @(posedge comm_clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_rr_ptr      <= '0;
         r_gidx        <= '0;
         r_grant       <= '0;
         r_wdog        <= '0;
         r_last_q      <= 1'b0;
         r_hold_cnt    <= 1'b0;
         r_tx_flag     <= 1'b0;
         r_tx_byte     <= 8'h00;
         r_timeout_err <= 1'b0;
      end else begin
         r_tx_flag     <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_gidx  <= w_winner;
                  r_grant <= w_winner_oh;
                  r_wdog  <= '0;
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               // Handshake is tested first so it wins over watchdog expiry.
               if (w_handshake) begin
                  r_tx_byte  <= w_g_data;
                  r_tx_flag  <= 1'b1;
                  r_last_q   <= w_g_last;
                  r_wdog     <= '0;
                  r_hold_cnt <= 1'b0;
                  r_state    <= S_HOLD;
               end else if (!w_g_valid) begin
                  if (r_wdog == WW'(TIMEOUT - 1)) begin
                     r_timeout_err <= 1'b1;
                     r_grant       <= '0;
                     r_rr_ptr      <= w_next_ptr;
                     r_wdog        <= '0;
                     r_state       <= S_IDLE;
                  end else begin
                     r_wdog <= r_wdog + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               // Second HOLD cycle gives up on busy so a silent uart_tx cannot hang us.
               if (tx_busy || r_hold_cnt) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_hold_cnt <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (!tx_busy) begin
                  if (r_last_q) begin
                     r_grant  <= '0;
                     r_rr_ptr <= w_next_ptr;
                     r_state  <= S_IDLE;
                  end else begin
                     r_state <= S_SEND;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (N_REQ=3, TIMEOUT=16).
// Sources are byte queues; a behavioural uart_tx stub logs every loaded byte.
module tb_uart_tx_arbiter;

   localparam int N  = 3;
   localparam int TO = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid;
   logic [8*N-1:0]   req_data;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     grant;
   logic             tx_flag;
   logic [7:0]       tx_byte;
   logic             tx_busy;
   logic             timeout_err;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .comm_clk    (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .grant       (grant),
      .tx_flag     (tx_flag),
      .tx_byte     (tx_byte),
      .tx_busy     (tx_busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [8:0]  q_src [N][$];      // {last, data}
   logic [7:0]  wire_q [$];
   int unsigned flag_cyc [$];
   logic [7:0]  exp_q [$];
   logic [8:0]  pk_bytes [N][$];
   int unsigned pk_len [N][$];

   logic [N-1:0] mid;
   int unsigned  gap_run [N];
   bit           gap_en, rnd_busy, stub, mon_en;
   int unsigned  busy_len = 4;
   int unsigned  busy_cnt;
   int unsigned  cyc = 0;
   int unsigned  n_terr;
   logic [7:0]   last_tx;
   logic [N-1:0] s_grant, s_ready;
   logic         s_flag, s_terr;

   typedef struct {
      logic [N-1:0] mask;
      logic [N-1:0] exp_grant;
      logic [7:0]   exp_byte;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_inputs();
      logic [N-1:0]   v, l;
      logic [8*N-1:0] d;
      bit             gap;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < N; i++) begin
         if (q_src[i].size() > 0) begin
            gap = 1'b0;
            if (gap_en && mid[i] && gap_run[i] < 5 && $urandom_range(0, 3) == 0) begin
               gap = 1'b1;
               gap_run[i]++;
            end else begin
               gap_run[i] = 0;
            end
            if (!gap) begin
               v[i]         = 1'b1;
               d[8*i +: 8]  = q_src[i][0][7:0];
               l[i]         = q_src[i][0][8];
            end
         end
      end
      req_valid = v;
      req_data  = d;
      req_last  = l;
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         q_src[i].delete();
         gap_run[i] = 0;
      end
      mid = '0;
      wire_q.delete();
      flag_cyc.delete();
      tx_busy  = 1'b0;
      busy_cnt = 0;
      n_terr   = 0;
      drive_inputs();
   endtask

   // One clock: sample at negedge, apply the edge's effects 1 time unit after posedge.
   task automatic tick();
      logic [N-1:0] hs;
      logic         fl;
      @(negedge clk);
      cyc++;
      s_grant = grant;
      s_ready = req_ready;
      s_flag  = tx_flag;
      s_terr  = timeout_err;
      hs      = req_valid & req_ready;
      fl      = tx_flag;
      if (tx_flag) begin
         wire_q.push_back(tx_byte);
         flag_cyc.push_back(cyc);
         last_tx = tx_byte;
      end
      if (tx_busy) chk("tx_byte_stable", 32'(tx_byte), 32'(last_tx));
      if (timeout_err) n_terr++;
      if (mon_en) begin
         chk("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
         chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i] && q_src[i].size() > 0) begin
            mid[i] = !q_src[i][0][8];
            void'(q_src[i].pop_front());
         end
      end
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (fl && !stub) begin
         tx_busy  = 1'b1;
         busy_cnt = rnd_busy ? $urandom_range(1, 6) : busy_len;
      end
      drive_inputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_model();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned nbytes, input int unsigned budget, input string tag);
      int unsigned k;
      k = 0;
      while (!(wire_q.size() >= nbytes && s_grant == '0 && !tx_busy) && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(k < budget), 32'd1);
   endtask

   task automatic chk_wire(input string tag, input int unsigned j, input logic [7:0] exp);
      chk(tag, (j < wire_q.size()) ? 32'(wire_q[j]) : 32'hDEAD, 32'(exp));
   endtask

   initial begin
      #1000000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned k_cyc, t_cyc, bad, nb, total, ptr, np, len, left, s;
      int unsigned rem [N];
      int unsigned bpos [N];
      int unsigned pidx [N];
      bit found;

      vecs[0] = '{3'b111, 3'b001, 8'hA0};
      vecs[1] = '{3'b111, 3'b010, 8'hA1};
      vecs[2] = '{3'b011, 3'b001, 8'hA0};
      vecs[3] = '{3'b100, 3'b100, 8'hA2};
      vecs[4] = '{3'b110, 3'b010, 8'hA1};
      vecs[5] = '{3'b101, 3'b100, 8'hA2};
      vecs[6] = '{3'b010, 3'b010, 8'hA1};
      vecs[7] = '{3'b011, 3'b001, 8'hA0};

      gap_en = 0; rnd_busy = 0; stub = 0; mon_en = 0;
      last_tx = 8'h00;
      s_grant = '0; s_ready = '0; s_flag = 0; s_terr = 0;
      reset = 1'b0;
      clear_model();
      #1 reset = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_tx_flag", 32'(tx_flag), 32'd0);
      chk("rst_tx_byte", 32'(tx_byte), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Arbitration table: each entry is a set of single-byte packets.
      foreach (vecs[v]) begin
         nb = wire_q.size();
         for (int i = 0; i < N; i++)
            if (vecs[v].mask[i]) q_src[i].push_back({1'b1, 8'hA0 + 8'(i)});
         k_cyc = 0;
         while (s_grant == '0 && k_cyc < 20) begin
            tick();
            k_cyc++;
         end
         chk("tbl_grant", 32'(s_grant), 32'(vecs[v].exp_grant));
         for (int i = 0; i < N; i++)
            if (!vecs[v].exp_grant[i]) q_src[i].delete();
         wait_idle(nb + 1, 60, "tbl_done");
         chk_wire("tbl_byte", nb, vecs[v].exp_byte);
      end

      // Single 3-byte packet from source 0.
      do_reset();
      q_src[0].push_back({1'b0, 8'h01});
      q_src[0].push_back({1'b0, 8'h21});
      q_src[0].push_back({1'b1, 8'hA5});
      bad = 0;
      for (int j = 0; j < 200 && !(wire_q.size() >= 3 && s_grant == '0 && !tx_busy); j++) begin
         tick();
         if (s_grant != '0 && s_grant != 3'b001) bad++;
         if (s_flag) chk("t1_grant_at_flag", 32'(s_grant), 32'b001);
      end
      chk("t1_foreign_grant", bad, 0);
      chk("t1_flags", wire_q.size(), 3);
      chk_wire("t1_b0", 0, 8'h01);
      chk_wire("t1_b1", 1, 8'h21);
      chk_wire("t1_b2", 2, 8'hA5);
      chk("t1_period", (flag_cyc.size() > 1) ? flag_cyc[1] - flag_cyc[0] : 0, busy_len + 3);
      chk("t1_grant_end", 32'(s_grant), 32'd0);

      // Simultaneous two-byte packets from sources 0 and 1.
      do_reset();
      q_src[0].push_back({1'b0, 8'h11});
      q_src[0].push_back({1'b1, 8'h12});
      q_src[1].push_back({1'b0, 8'h21});
      q_src[1].push_back({1'b1, 8'h22});
      wait_idle(4, 200, "t2_done");
      chk_wire("t2_b0", 0, 8'h11);
      chk_wire("t2_b1", 1, 8'h12);
      chk_wire("t2_b2", 2, 8'h21);
      chk_wire("t2_b3", 3, 8'h22);
      // Pointer now sits at 2; scanning 2,0,1 picks source 0.
      q_src[0].push_back({1'b1, 8'h13});
      q_src[1].push_back({1'b1, 8'h23});
      wait_idle(6, 200, "t2b_done");
      chk_wire("t2b_b0", 4, 8'h13);
      chk_wire("t2b_b1", 5, 8'h23);

      // Source 1 arrives mid-packet of source 0.
      do_reset();
      q_src[0].push_back({1'b0, 8'h31});
      q_src[0].push_back({1'b0, 8'h32});
      q_src[0].push_back({1'b1, 8'h33});
      for (int j = 0; j < 50 && wire_q.size() < 1; j++) tick();
      q_src[1].push_back({1'b1, 8'h41});
      bad = 0;
      for (int j = 0; j < 200 && !(wire_q.size() >= 4 && s_grant == '0 && !tx_busy); j++) begin
         tick();
         if (wire_q.size() < 3 && s_ready[1]) bad++;
      end
      chk("t3_ready1_while_locked", bad, 0);
      chk_wire("t3_b0", 0, 8'h31);
      chk_wire("t3_b2", 2, 8'h33);
      chk_wire("t3_b3", 3, 8'h41);

      // Watchdog: source 0 stalls after its first byte, source 1 waits.
      do_reset();
      q_src[0].push_back({1'b0, 8'h51});
      q_src[1].push_back({1'b1, 8'h61});
      k_cyc = 0;
      t_cyc = 0;
      for (int j = 0; j < 200 && t_cyc == 0; j++) begin
         tick();
         if (wire_q.size() >= 1 && k_cyc == 0 && s_grant == 3'b001 && s_ready[0]) k_cyc = cyc;
         if (s_terr) begin
            t_cyc = cyc;
            chk("t4_grant_at_abort", 32'(s_grant), 32'd0);
         end
      end
      chk("t4_abort_latency", t_cyc - k_cyc, TO);
      wait_idle(2, 200, "t4_done");
      repeat (5) tick();
      chk("t4_terr_pulses", n_terr, 1);
      chk_wire("t4_b1", 1, 8'h61);

      // Asynchronous reset while draining byte 2 of 3.
      do_reset();
      q_src[0].push_back({1'b0, 8'h71});
      q_src[0].push_back({1'b0, 8'h72});
      q_src[0].push_back({1'b1, 8'h73});
      for (int j = 0; j < 100 && wire_q.size() < 2; j++) tick();
      tick();
      tick();
      chk("t5_in_drain_busy", 32'(tx_busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_grant", 32'(grant), 32'd0);
      chk("t5_rst_ready", 32'(req_ready), 32'd0);
      chk("t5_rst_flag", 32'(tx_flag), 32'd0);
      chk("t5_rst_byte", 32'(tx_byte), 32'd0);
      chk("t5_rst_terr", 32'(timeout_err), 32'd0);
      clear_model();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      q_src[1].push_back({1'b0, 8'h7A});
      q_src[1].push_back({1'b1, 8'h7B});
      wait_idle(2, 200, "t5_done");
      chk("t5_count", wire_q.size(), 2);
      chk_wire("t5_b0", 0, 8'h7A);
      chk_wire("t5_b1", 1, 8'h7B);

      // Transmitter that never raises busy.
      do_reset();
      stub = 1;
      q_src[0].push_back({1'b0, 8'h81});
      q_src[0].push_back({1'b0, 8'h82});
      q_src[0].push_back({1'b1, 8'h83});
      wait_idle(3, 200, "t6_done");
      chk_wire("t6_b2", 2, 8'h83);
      chk("t6_period", (flag_cyc.size() > 2) ? flag_cyc[2] - flag_cyc[1] : 0, 4);
      stub = 0;

      // Randomized rounds against an order-of-service model.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         gap_en = 1; rnd_busy = 1; mon_en = 1;
         exp_q.delete();
         total = 0;
         for (int i = 0; i < N; i++) begin
            pk_bytes[i].delete();
            pk_len[i].delete();
            np = $urandom_range(0, 3);
            if (i == 0 && np == 0) np = 1;
            for (int p = 0; p < int'(np); p++) begin
               len = $urandom_range(1, 4);
               pk_len[i].push_back(len);
               for (int b = 0; b < int'(len); b++)
                  pk_bytes[i].push_back({(b == int'(len) - 1) ? 1'b1 : 1'b0, 8'($urandom)});
               total += len;
            end
            rem[i]  = pk_len[i].size();
            bpos[i] = 0;
            pidx[i] = 0;
         end
         ptr  = 0;
         left = 0;
         for (int i = 0; i < N; i++) left += rem[i];
         while (left > 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               s = (ptr + k) % N;
               if (!found && rem[s] > 0) begin
                  found = 1;
                  len = pk_len[s][pidx[s]];
                  for (int b = 0; b < int'(len); b++) exp_q.push_back(pk_bytes[s][bpos[s] + b][7:0]);
                  bpos[s] += len;
                  pidx[s]++;
                  rem[s]--;
                  left--;
                  ptr = (s + 1) % N;
               end
            end
         end
         for (int i = 0; i < N; i++)
            foreach (pk_bytes[i][b]) q_src[i].push_back(pk_bytes[i][b]);
         wait_idle(total, 3000, "rnd_done");
         chk("rnd_count", wire_q.size(), total);
         for (int j = 0; j < int'(total); j++) chk_wire("rnd_byte", j, exp_q[j]);
         chk("rnd_no_timeout", n_terr, 0);
         gap_en = 0; rnd_busy = 0; mon_en = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
